// File: rtl/input_port_fifo_xy.sv
// Mesh router input port: RTS/CTS receive link, flit FIFO and XY route request.
// One request line is held high from header routing until the tail flit pops.
module input_port_fifo_xy #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int COORD_W    = 2,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DRTS,
    input  logic [DATA_WIDTH-1:0] RX,
    output logic                  CTS,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] flit_out,
    output logic                  empty,
    output logic                  Req_N,
    output logic                  Req_E,
    output logic                  Req_W,
    output logic                  Req_S,
    output logic                  Req_L,
    output logic                  err_flit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

    localparam logic [4:0] R_N = 5'b10000;
    localparam logic [4:0] R_E = 5'b01000;
    localparam logic [4:0] R_W = 5'b00100;
    localparam logic [4:0] R_S = 5'b00010;
    localparam logic [4:0] R_L = 5'b00001;

    typedef enum logic {IDLE, ROUTE} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  cts_q;
    state_t                state;
    state_t                state_d;
    logic [4:0]            req_q;
    logic [4:0]            req_d;
    logic                  err_q;
    logic                  err_d;

    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            ftype;
    logic                  is_hdr;
    logic                  is_tail;
    logic [COORD_W-1:0]    dst_x;
    logic [COORD_W-1:0]    dst_y;
    logic [4:0]            route;
    logic                  full;
    logic                  empty_w;
    logic                  write;
    logic                  drop;
    logic                  pop;

    assign head    = mem[rd_ptr];
    assign ftype   = head[DATA_WIDTH-1 -: 3];
    assign is_hdr  = (ftype == 3'b001);
    assign is_tail = (ftype == 3'b100);
    assign dst_x   = head[COORD_W-1:0];
    assign dst_y   = head[2*COORD_W-1:COORD_W];

    assign full    = (count == CW'(DEPTH));
    assign empty_w = (count == '0);
    // ~cts_q keeps a flit held across its acknowledge cycle from being written twice
    assign write   = DRTS & ~cts_q & ~full;
    assign drop    = (state == IDLE) & ~empty_w & ~is_hdr;
    assign pop     = ~empty_w & (read_en | drop);

    always_comb begin
        route = R_L;
        if (dst_x > CX)
            route = R_E;
        else if (dst_x < CX)
            route = R_W;
        else if (dst_y > CY)
            route = R_S;
        else if (dst_y < CY)
            route = R_N;
    end

    always_comb begin
        state_d = state;
        req_d   = req_q;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty_w) begin
                    if (is_hdr) begin
                        req_d   = route;
                        state_d = ROUTE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ROUTE: begin
                if (pop && is_tail) begin
                    req_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (write)
            mem[wr_ptr] <= RX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cts_q  <= 1'b0;
            state  <= IDLE;
            req_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            cts_q <= write;
            state <= state_d;
            req_q <= req_d;
            err_q <= err_d;
            if (write)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({write, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign CTS      = cts_q;
    assign flit_out = head;
    assign empty    = empty_w;
    assign Req_N    = req_q[4];
    assign Req_E    = req_q[3];
    assign Req_W    = req_q[2];
    assign Req_S    = req_q[1];
    assign Req_L    = req_q[0];
    assign err_flit = err_q;

endmodule

// File: doc/input_port_fifo_xy.md
Name: input_port_fifo_xy

Overview:
- Per-direction input stage of the 5-port (N/E/W/S/L) mesh router.
- Accepts flits from the neighbouring router or local core over the RTS/CTS link handshake and buffers them in a small FIFO.
- Performs XY route computation on each header flit and drives the one-hot Req_N..Req_L lines consumed by the downstream per-output arbiters.
- Holds the request until the packet's tail flit has been read out.

Parameters:
- DATA_WIDTH, 32, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-3] are the flit type: 001 header, 010 body, 100 tail.
- DEPTH, 4, FIFO depth in flits; power of two, >= 2.
- COORD_W, 2, width of each coordinate field in the header.
- CUR_X, 0, this router's X coordinate.
- CUR_Y, 0, this router's Y coordinate.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- DRTS  in  1  upstream request-to-send; held by the sender until it sees CTS=1.
- RX  in  DATA_WIDTH  upstream flit, valid while DRTS=1.
- CTS  out  1  clear-to-send; one-cycle registered pulse acknowledging one write.
- read_en  in  1  pop FIFO head; OR of the grants this port received from the output arbiters.
- flit_out  out  DATA_WIDTH  FIFO head flit (combinational from storage); don't-care when empty.
- empty  out  1  FIFO empty.
- Req_N, Req_E, Req_W, Req_S, Req_L  out  1 each  registered request to the output arbiters; at most one high.
- err_flit  out  1  one-cycle pulse when a non-header flit is discarded at the head in IDLE.

Behaviour:
Reset:
- Synchronous, active-high.
- Pointers = 0, count = 0, empty = 1, CTS = 0, all Req_* = 0, err_flit = 0, FSM = IDLE.
- Storage contents are not reset.
- Reset asserted mid-packet flushes the FIFO and drops requests on the next edge.

Write side:
- Write condition: write = DRTS & ~CTS & ~full.
- On write, RX goes to mem[wr_ptr], wr_ptr increments with wrap at DEPTH, and CTS goes to 1 on that edge.
- CTS always drops the following cycle.
- Because of the ~CTS term, a flit held across the acknowledge cycle is never written twice.
- When full, CTS stays 0 and the sender stalls; no overflow is possible.

Read side:
- pop = read_en & ~empty.
- read_en while empty is ignored: no pointer change and no underflow.
- Simultaneous write and pop: both occur and count is unchanged.
- A write while full is blocked even if pop happens in the same cycle, because full is evaluated before the edge.
- Latency: a flit written at edge k appears at flit_out (empty=0) after edge k.

Route FSM states: IDLE, ROUTE.
- IDLE, empty=1: stay.
- IDLE, head type = header: compute the route from dst_x = head[COORD_W-1:0] and dst_y = head[2*COORD_W-1:COORD_W]:
  - dst_x > CUR_X: E
  - dst_x < CUR_X: W
  - else dst_y > CUR_Y: S (Y grows southward)
  - else dst_y < CUR_Y: N
  - else: L
- The selected Req_* is registered high at the next edge and the FSM moves to ROUTE. A header is therefore at the head for at least one cycle before its request appears.
- IDLE, head is a non-header flit: pop it internally, pulse err_flit for 1 cycle, stay in IDLE.
- ROUTE: hold Req_* constant. Each pop advances the head. When a popped flit is a tail, all Req_* clear at that edge and the FSM returns to IDLE.
- Back-to-back packets: the next header is routed in the IDLE cycle after the tail, so there is a one-cycle request gap between packets.
- A header or unknown type popped while in ROUTE is forwarded unchanged; only the tail ends the packet.

Widths:
- Pointers are clog2(DEPTH) bits and wrap naturally.
- count is clog2(DEPTH+1) bits.
- full = (count == DEPTH).

Test Plan:
1. Reset, then CUR=(1,1); send header dst=(2,1) via DRTS with a sender that drops DRTS on CTS → CTS pulses 1 cycle; empty=0 one cycle after write; Req_E=1 one cycle later, other Req_*=0.
2. Headers dst (0,1), (1,0), (1,2), (1,1), each followed by a tail and popped → Req_W, Req_N, Req_S, Req_L in turn; one-cycle all-zero gap between packets.
3. DEPTH=4; write 4 flits (header, body, body, body) with read_en=0 → full, CTS stays 0 for a 5th DRTS held 10 cycles; pop once → the 5th flit is accepted and count returns to 4.
4. Hold DRTS=1 continuously with constant RX for 6 cycles → exactly 3 writes (CTS alternates 1,0), never two writes per flit.
5. Body flit 0x4000_0000 at the head while IDLE → popped internally, err_flit pulses once, no Req_*; a following header routes normally.
6. Assert rst mid-packet (Req_S high, 2 flits stored) → next edge: empty=1, Req_S=0, CTS=0, FSM in IDLE; read_en on the empty FIFO has no effect.
